// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared widths, M-extension opcodes, FSM states and opcode
//               decode helpers for the muldiv sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [4:0] OP_MUL    = 5'b01001;
  localparam logic [4:0] OP_MULH   = 5'b01010;
  localparam logic [4:0] OP_MULHU  = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_DIV    = 5'b01101;
  localparam logic [4:0] OP_DIVU   = 5'b01110;
  localparam logic [4:0] OP_REM    = 5'b01111;
  localparam logic [4:0] OP_REMU   = 5'b10000;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The eight ops occupy the contiguous code range MUL..REMU.
  function automatic logic op_valid(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic op_is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic op_a_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_core.sv
// ============================================================================
// Module      : muldiv_core
// Description : 64-bit shift register datapath: shift-add multiply and
//               restoring divide on magnitudes, plus sign/half result select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_load_div,
  input  logic            i_step,
  input  logic [4:0]      i_op,
  input  logic            i_sa,
  input  logic            i_sb,
  input  logic [XLEN-1:0] i_opa,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN-1:0] o_result
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_dvs;
  logic              r_div;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;

  // Multiply: upper half accumulates, multiplier drains out of the lower half.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_dvs} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: remainder in upper half, quotient bits shift into the lower half.
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_dvs};
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_dvs <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_div <= i_load_div;
      r_dvs <= i_load_div ? i_opb : i_opa;
      r_acc <= {{XLEN{1'b0}}, (i_load_div ? i_opa : i_opb)};
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  assign w_prod = (i_sa ^ i_sb) ? -r_acc : r_acc;
  assign w_quo  = (i_sa ^ i_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = i_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_MUL:                        o_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU:  o_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               o_result = w_quo;
      OP_REM, OP_REMU:               o_result = w_rem;
      default:                       o_result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq_ctrl.sv
// ============================================================================
// Module      : muldiv_seq_ctrl
// Description : Multi-cycle M-extension sequencer; stalls the pipeline while
//               the iterative core runs. MULDIV_FAST_MUL_EN selects a
//               single-cycle multiply for MUL* ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [4:0]      alu_opcode_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_op;
  logic             r_sa;
  logic             r_sb;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  logic             w_valid;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_div0;
  logic             w_ovf;
  logic             w_accept;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic [XLEN-1:0]  w_special;
  logic [XLEN-1:0]  w_core_result;

  assign w_valid  = op_valid(alu_opcode_i);
  assign w_a_neg  = op_a_signed(alu_opcode_i) & opa_i[XLEN-1];
  assign w_b_neg  = op_b_signed(alu_opcode_i) & opb_i[XLEN-1];
  assign w_abs_a  = w_a_neg ? -opa_i : opa_i;
  assign w_abs_b  = w_b_neg ? -opb_i : opb_i;
  assign w_div0   = op_is_div(alu_opcode_i) && (opb_i == '0);
  assign w_ovf    = ((alu_opcode_i == OP_DIV) || (alu_opcode_i == OP_REM)) &&
                    (opa_i == INT_MIN) && (opb_i == '1);
  assign w_accept = (r_state == ST_IDLE) && start_i && w_valid && !flush_i;

  // Architected results for cases that skip the iteration entirely.
  assign w_special = w_div0 ? (((alu_opcode_i == OP_DIV) || (alu_opcode_i == OP_DIVU)) ? '1 : opa_i)
                            : ((alu_opcode_i == OP_DIV) ? INT_MIN : '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_ea;
  logic [2*XLEN-1:0] w_fast_eb;
  logic [2*XLEN-1:0] w_fast_prod;
  logic [XLEN-1:0]   w_fast_res;

  assign w_fast_ea   = {{XLEN{op_a_signed(alu_opcode_i) & opa_i[XLEN-1]}}, opa_i};
  assign w_fast_eb   = {{XLEN{op_b_signed(alu_opcode_i) & opb_i[XLEN-1]}}, opb_i};
  assign w_fast_prod = w_fast_ea * w_fast_eb;
  assign w_fast_res  = (alu_opcode_i == OP_MUL) ? w_fast_prod[XLEN-1:0]
                                                : w_fast_prod[2*XLEN-1:XLEN];
`endif

  muldiv_core u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_load_div (op_is_div(alu_opcode_i)),
    .i_step     ((r_state == ST_CALC) && !flush_i),
    .i_op       (r_op),
    .i_sa       (r_sa),
    .i_sb       (r_sb),
    .i_opa      (w_abs_a),
    .i_opb      (w_abs_b),
    .o_result   (w_core_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i && w_valid) begin
              r_op <= alu_opcode_i;
              r_sa <= w_a_neg;
              r_sb <= w_b_neg;
              if (w_div0 || w_ovf) begin
                r_result <= w_special;
                r_done   <= 1'b1;
                r_state  <= ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
              end else if (!op_is_div(alu_opcode_i)) begin
                r_result <= w_fast_res;
                r_done   <= 1'b1;
                r_state  <= ST_DONE;
`endif
              end else begin
                r_cnt   <= '0;
                r_state <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN-1)) begin
              r_state <= ST_FIX;
            end
          end
          ST_FIX: begin
            r_result <= w_core_result;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign stall_o  = ((r_state == ST_IDLE) && start_i && w_valid) ||
                    (r_state == ST_CALC) || (r_state == ST_FIX);
  assign busy_o   = (r_state != ST_IDLE);
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

`default_nettype wire
